beat_sound_scheduler: RTL and testbench

Sequences the shared tone generator between two requesters: beat events from the accelerometer beat detector, and a melody/keypad source using a request/grant handshake. Beats have priority and can preempt a melody note. Beats that arrive while the generator is busy are queued in a saturating pending counter. A silent guard gap is enforced between notes. Sits between the beat detector and the tone synthesizer in the sound path.

---
 rtl/beat_sound_scheduler_pkg.sv | 38 +++
 rtl/beat_sound_scheduler_if.sv | 26 ++
 rtl/beat_sound_scheduler_tone_timer.sv | 35 +++
 rtl/beat_sound_scheduler.sv | 165 ++++++++++++++++
 tb/tb_beat_sound_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/beat_sound_scheduler_pkg.sv
// Shared types and constants for the beat/melody tone scheduler.
package beat_sound_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BEAT_PLAY = 2'd1,
    MEL_PLAY  = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam int unsigned TONE_W = 32'd8;
  localparam int unsigned VOL_W  = 32'd2;
  localparam int unsigned PEND_W = 32'd3;

  localparam logic [TONE_W-1:0] DEFAULT_BEAT_TONE = 8'd60;
  localparam logic [VOL_W-1:0]  MEL_VOLUME        = 2'b10;
  localparam logic [VOL_W-1:0]  MIN_VOLUME        = 2'b01;

  // A zero-intensity beat would be inaudible, so it is lifted to the quietest level.
  function automatic logic [VOL_W-1:0] beat_volume(input logic [VOL_W-1:0] intensity);
    logic [VOL_W-1:0] vol;
    if (intensity == 2'b00) begin
      vol = MIN_VOLUME;
    end else begin
      vol = intensity;
    end
    return vol;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/beat_sound_scheduler_if.sv
// Requester-side and synthesizer-side signals of the tone scheduler.
interface beat_sound_scheduler_if;
  import beat_sound_pkg::*;

  logic              beat_en;
  logic [VOL_W-1:0]  beat_intensity;
  logic              mel_req;
  logic [TONE_W-1:0] mel_tone;
  logic              mel_gnt;
  logic              tone_start;
  logic [TONE_W-1:0] tone_code;
  logic [VOL_W-1:0]  tone_volume;
  logic              tone_active;
  logic              beat_dropped;
  logic [PEND_W-1:0] pend_cnt;

  modport master (
    output beat_en, beat_intensity, mel_req, mel_tone,
    input  mel_gnt, tone_start, tone_code, tone_volume, tone_active, beat_dropped, pend_cnt
  );

  modport slave (
    input  beat_en, beat_intensity, mel_req, mel_tone,
    output mel_gnt, tone_start, tone_code, tone_volume, tone_active, beat_dropped, pend_cnt
  );
endinterface

// File: rtl/beat_sound_scheduler_tone_timer.sv
// Loadable down-counter with zero flag; holds at zero until the next load.
module tone_timer #(
  parameter int unsigned W = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/beat_sound_scheduler.sv
// Arbitrates the shared tone generator between queued beats and melody requests.
module beat_sound_scheduler
  import beat_sound_pkg::*;
#(
  parameter logic [7:0]  BEAT_TONE = DEFAULT_BEAT_TONE,
  parameter int unsigned BEAT_LEN  = 32'd2500000,
  parameter int unsigned MEL_LEN   = 32'd5000000,
  parameter int unsigned GAP_LEN   = 32'd250000,
  parameter int unsigned MAX_PEND  = 32'd3,
  parameter int unsigned PREEMPT   = 32'd1
) (
  input logic                    clk,
  input logic                    rst,
  beat_sound_scheduler_if.slave  bus
);

  localparam int unsigned TW = $clog2(max3(BEAT_LEN, MEL_LEN, GAP_LEN));
  localparam logic [TW-1:0]     BEAT_LOAD = TW'(BEAT_LEN - 32'd1);
  localparam logic [TW-1:0]     MEL_LOAD  = TW'(MEL_LEN - 32'd1);
  localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_LEN - 32'd1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [VOL_W-1:0]  last_int_q, last_int_d;
  logic              gnt_q, gnt_d;
  logic              start_q, start_d;
  logic [TONE_W-1:0] code_q, code_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic              active_q, active_d;
  logic              drop_q, drop_d;

  logic              tmr_load_s;
  logic [TW-1:0]     tmr_val_s;
  logic              tmr_zero_s;
  logic              beat_take_s;
  logic              preempt_s;

  tone_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  assign preempt_s = (PREEMPT != 32'd0) && (pend_q != 3'd0);

  // A beat_en arriving in IDLE holds off the melody so the beat is served first.
  always_comb begin
    state_d     = state_q;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;
    gnt_d       = 1'b0;
    start_d     = 1'b0;
    code_d      = code_q;
    vol_d       = vol_q;
    beat_take_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != 3'd0) begin
          start_d     = 1'b1;
          code_d      = BEAT_TONE;
          vol_d       = beat_volume(last_int_q);
          tmr_load_s  = 1'b1;
          tmr_val_s   = BEAT_LOAD;
          beat_take_s = 1'b1;
          state_d     = BEAT_PLAY;
        end else if (bus.mel_req && !bus.beat_en) begin
          gnt_d      = 1'b1;
          start_d    = 1'b1;
          code_d     = bus.mel_tone;
          vol_d      = MEL_VOLUME;
          tmr_load_s = 1'b1;
          tmr_val_s  = MEL_LOAD;
          state_d    = MEL_PLAY;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT_PLAY: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
          state_d    = GAP;
        end else begin
          state_d = BEAT_PLAY;
        end
      end
      MEL_PLAY: begin
        if (preempt_s || tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
          state_d    = GAP;
        end else begin
          state_d = MEL_PLAY;
        end
      end
      GAP: begin
        if (tmr_zero_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    active_d = (state_d == BEAT_PLAY) || (state_d == MEL_PLAY);
  end

  always_comb begin
    pend_d     = pend_q;
    drop_d     = 1'b0;
    last_int_d = last_int_q;
    if (bus.beat_en) begin
      last_int_d = bus.beat_intensity;
      if (beat_take_s) begin
        pend_d = pend_q;
      end else if (pend_q == PEND_MAX) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + 3'd1;
      end
    end else if (beat_take_s) begin
      pend_d = pend_q - 3'd1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      last_int_q <= '0;
      gnt_q      <= 1'b0;
      start_q    <= 1'b0;
      code_q     <= '0;
      vol_q      <= '0;
      active_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      last_int_q <= last_int_d;
      gnt_q      <= gnt_d;
      start_q    <= start_d;
      code_q     <= code_d;
      vol_q      <= vol_d;
      active_q   <= active_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.mel_gnt      = gnt_q;
  assign bus.tone_start   = start_q;
  assign bus.tone_code    = code_q;
  assign bus.tone_volume  = vol_q;
  assign bus.tone_active  = active_q;
  assign bus.beat_dropped = drop_q;
  assign bus.pend_cnt     = pend_q;

endmodule

// File: tb/tb_beat_sound_scheduler.sv
// Directed, table-driven bench for beat_sound_scheduler with short note lengths.
module tb_beat_sound_scheduler;

  typedef struct {
    int          reps;
    logic        be;
    logic [1:0]  bi;
    logic        mr;
    logic [7:0]  mt;
    logic [16:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  beat_sound_scheduler_if bus();

  beat_sound_scheduler #(
    .BEAT_TONE (8'd60),
    .BEAT_LEN  (32'd8),
    .MEL_LEN   (32'd12),
    .GAP_LEN   (32'd2),
    .MAX_PEND  (32'd3),
    .PREEMPT   (32'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input logic g, input logic s, input logic [7:0] c,
                                     input logic [1:0] v, input logic a, input logic d,
                                     input logic [2:0] p);
    return {g, s, c, v, a, d, p};
  endfunction

  function automatic vec_t mk(input int reps, input logic be, input logic [1:0] bi,
                              input logic mr, input logic [7:0] mt, input logic g,
                              input logic s, input logic [7:0] c, input logic [1:0] v,
                              input logic a, input logic d, input logic [2:0] p);
    vec_t r;
    r.reps = reps; r.be = be; r.bi = bi; r.mr = mr; r.mt = mt;
    r.exp  = pk(g, s, c, v, a, d, p);
    return r;
  endfunction

  function automatic logic [16:0] outs();
    return {bus.mel_gnt, bus.tone_start, bus.tone_code, bus.tone_volume,
            bus.tone_active, bus.beat_dropped, bus.pend_cnt};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: gnt/start/code/vol/active/drop/pend got %b/%b/%0d/%0d/%b/%b/%0d want %b/%b/%0d/%0d/%b/%b/%0d",
               name, got[16], got[15], got[14:7], got[6:5], got[4], got[3], got[2:0],
               want[16], want[15], want[14:7], want[6:5], want[4], want[3], want[2:0]);
    end
  endtask

  task automatic cyc(input logic r, input logic be, input logic [1:0] bi, input logic mr,
                     input logic [7:0] mt, input logic [16:0] want, input string name);
    @(negedge clk);
    rst = r; bus.beat_en = be; bus.beat_intensity = bi; bus.mel_req = mr; bus.mel_tone = mt;
    @(posedge clk);
    #1;
    check(name, outs(), want);
  endtask

  initial begin
    int n;
    int act;
    bus.beat_en = 1'b0; bus.beat_intensity = 2'b00; bus.mel_req = 1'b0; bus.mel_tone = 8'h00;

    // Reset, then a beat note interrupted by reset.
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, pk(0, 0, 8'd0, 2'd0, 0, 0, 3'd0), "reset0");
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, pk(0, 0, 8'd0, 2'd0, 0, 0, 3'd0), "reset1");
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 8'h00, pk(0, 0, 8'd0, 2'd0, 0, 0, 3'd1), "rst_beat");
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, pk(0, 1, 8'd60, 2'd2, 1, 0, 3'd0), "rst_start");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, pk(0, 0, 8'd60, 2'd2, 1, 0, 3'd0), "rst_play");
    cyc(1'b0, 1'b1, 2'd3, 1'b0, 8'h00, pk(0, 0, 8'd0, 2'd0, 0, 0, 3'd0), "mid_reset");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, pk(0, 0, 8'd0, 2'd0, 0, 0, 3'd0), "post_reset");

    // reps, be, bi, mr, mt | gnt, start, code, vol, active, drop, pend
    vq.push_back(mk(1,  1, 3, 0, 8'h00, 0, 0, 8'd0,  2'd0, 0, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd3, 1, 0, 3'd0));
    vq.push_back(mk(1,  0, 0, 1, 8'h33, 0, 0, 8'd60, 2'd3, 1, 0, 3'd0));
    vq.push_back(mk(6,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 0, 0, 3'd0));
    vq.push_back(mk(2,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 0, 0, 3'd0));
    vq.push_back(mk(1,  0, 0, 1, 8'h45, 1, 1, 8'h45, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(11, 0, 0, 0, 8'h00, 0, 0, 8'h45, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'h45, 2'd2, 0, 0, 3'd0));
    vq.push_back(mk(1,  0, 0, 1, 8'h50, 1, 1, 8'h50, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'h50, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(1,  1, 0, 0, 8'h00, 0, 0, 8'h50, 2'd2, 1, 0, 3'd1));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'h50, 2'd2, 0, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd1, 1, 0, 3'd0));
    vq.push_back(mk(7,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 0, 0, 3'd0));
    vq.push_back(mk(1,  1, 1, 0, 8'h00, 0, 0, 8'd60, 2'd1, 0, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd1, 1, 0, 3'd0));
    vq.push_back(mk(1,  1, 2, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd1));
    vq.push_back(mk(1,  1, 3, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd2));
    vq.push_back(mk(1,  1, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd3));
    vq.push_back(mk(1,  1, 1, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 1, 3'd3));
    vq.push_back(mk(1,  1, 2, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 1, 3'd3));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 1, 0, 3'd3));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd1, 0, 0, 3'd3));
    vq.push_back(mk(1,  1, 3, 0, 8'h00, 0, 1, 8'd60, 2'd2, 1, 0, 3'd3));
    vq.push_back(mk(7,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd2, 1, 0, 3'd3));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd2, 0, 0, 3'd3));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd3, 1, 0, 3'd2));
    vq.push_back(mk(7,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 1, 0, 3'd2));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 0, 0, 3'd2));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd3, 1, 0, 3'd1));
    vq.push_back(mk(7,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 1, 0, 3'd1));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 0, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 0, 8'h00, 0, 1, 8'd60, 2'd3, 1, 0, 3'd0));
    vq.push_back(mk(7,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'd60, 2'd3, 0, 0, 3'd0));
    vq.push_back(mk(1,  1, 1, 1, 8'h77, 0, 0, 8'd60, 2'd3, 0, 0, 3'd1));
    vq.push_back(mk(1,  0, 0, 1, 8'h77, 0, 1, 8'd60, 2'd1, 1, 0, 3'd0));
    vq.push_back(mk(7,  0, 0, 1, 8'h77, 0, 0, 8'd60, 2'd1, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 1, 8'h77, 0, 0, 8'd60, 2'd1, 0, 0, 3'd0));
    vq.push_back(mk(1,  0, 0, 1, 8'h77, 1, 1, 8'h77, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(11, 0, 0, 0, 8'h00, 0, 0, 8'h77, 2'd2, 1, 0, 3'd0));
    vq.push_back(mk(3,  0, 0, 0, 8'h00, 0, 0, 8'h77, 2'd2, 0, 0, 3'd0));

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].reps; r++)
        cyc(1'b1, vq[i].be, vq[i].bi, vq[i].mr, vq[i].mt, vq[i].exp,
            $sformatf("row%0d.%0d", i, r));
    end

    // Beat-to-start latency and note length, each bounded by a cycle budget.
    @(negedge clk);
    bus.beat_en = 1'b1; bus.beat_intensity = 2'd2;
    @(posedge clk); #1;
    n = 1;
    @(negedge clk);
    bus.beat_en = 1'b0;
    while (!bus.tone_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (n != 2) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles want 2", n);
    end
    act = 0;
    while (bus.tone_active && act < 30) begin
      act++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (act != 8) begin
      n_bad++;
      $display("FAIL active_len: got %0d cycles want 8", act);
    end
    repeat (4) @(posedge clk);
    #1;
    check("final_idle", outs(), pk(0, 0, 8'd60, 2'd2, 0, 0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
